// File: rtl/dcache_responder.sv
// Direct-mapped, write-through, no-write-allocate data cache for the MEM stage.
// Loads that miss and all stores go to backing memory over a req/ack handshake.
module dcache_responder #(
  parameter int INDEX_BITS = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] Address,
  input  logic [31:0] WriteData,
  input  logic        MemRead,
  input  logic        MemWrite,
  output logic [31:0] ReadData,
  output logic        MemStall,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic [31:0] hit_count,
  output logic [31:0] miss_count,
  output logic [1:0]  state_dbg
);

  localparam int LINES = 1 << INDEX_BITS;
  localparam int TAG_W = 32 - INDEX_BITS;

  // Handshake: mem_req rises with mem_we/mem_addr/mem_wdata and holds them
  // unchanged until a cycle where mem_ack=1 is sampled; that edge drops mem_req.
  // mem_ack while mem_req=0 has no effect.
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RD_MISS = 2'd1,
    WR_THRU = 2'd2,
    DONE    = 2'd3
  } state_t;

  state_t                  state;
  logic [LINES-1:0]        valid;
  logic [TAG_W-1:0]        tags [LINES];
  logic [31:0]             lines [LINES];
  logic [31:0]             fill_buf;
  logic                    done_load;

  logic [INDEX_BITS-1:0]   idx;
  logic [TAG_W-1:0]        tag;
  logic                    hit;

  assign idx       = Address[INDEX_BITS-1:0];
  assign tag       = Address[31:INDEX_BITS];
  assign hit       = valid[idx] && (tags[idx] == tag);
  assign state_dbg = state;

  // Stall and load data are combinational so a hit costs no extra cycle.
  always_comb begin
    MemStall = 1'b0;
    ReadData = 32'd0;
    if (!rst) begin
      case (state)
        IDLE: begin
          if (MemWrite) begin
            MemStall = 1'b1;
          end else if (MemRead) begin
            if (hit) ReadData = lines[idx];
            else     MemStall = 1'b1;
          end
        end
        RD_MISS, WR_THRU: MemStall = 1'b1;
        DONE: begin
          if (done_load) ReadData = fill_buf;
        end
        default: MemStall = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      valid      <= '0;
      mem_req    <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= 32'd0;
      mem_wdata  <= 32'd0;
      hit_count  <= 32'd0;
      miss_count <= 32'd0;
      fill_buf   <= 32'd0;
      done_load  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (MemWrite) begin
            mem_req   <= 1'b1;
            mem_we    <= 1'b1;
            mem_addr  <= Address;
            mem_wdata <= WriteData;
            state     <= WR_THRU;
          end else if (MemRead) begin
            if (hit) begin
              if (hit_count != 32'hFFFF_FFFF) hit_count <= hit_count + 32'd1;
            end else begin
              if (miss_count != 32'hFFFF_FFFF) miss_count <= miss_count + 32'd1;
              mem_req  <= 1'b1;
              mem_we   <= 1'b0;
              mem_addr <= Address;
              state    <= RD_MISS;
            end
          end
        end
        RD_MISS: begin
          if (mem_ack) begin
            mem_req    <= 1'b0;
            valid[idx] <= 1'b1;
            fill_buf   <= mem_rdata;
            done_load  <= 1'b1;
            state      <= DONE;
          end
        end
        WR_THRU: begin
          if (mem_ack) begin
            mem_req   <= 1'b0;
            done_load <= 1'b0;
            state     <= DONE;
          end
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Line storage carries no reset; the valid bits gate every use of it.
  always_ff @(posedge clk) begin
    if (!rst && mem_ack) begin
      if (state == RD_MISS) begin
        lines[idx] <= mem_rdata;
        tags[idx]  <= tag;
      end else if (state == WR_THRU && hit) begin
        lines[idx] <= WriteData;
      end
    end
  end

endmodule

// File: tb/tb_dcache_responder.sv
// Bench for dcache_responder: directed scenarios plus random accesses checked
// every cycle against a transaction-level cache model.
module tb_dcache_responder;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] address, write_data;
  logic        mem_read, mem_write;
  logic [31:0] read_data;
  logic        mem_stall;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic [31:0] hit_count, miss_count;
  logic [1:0]  state_dbg;

  always #5 clk = ~clk;

  dcache_responder #(.INDEX_BITS(4)) dut (
    .clk(clk), .rst(rst),
    .Address(address), .WriteData(write_data),
    .MemRead(mem_read), .MemWrite(mem_write),
    .ReadData(read_data), .MemStall(mem_stall),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .hit_count(hit_count), .miss_count(miss_count),
    .state_dbg(state_dbg)
  );

  typedef struct {
    bit          en;
    bit          stall;
    bit          pop;
    bit          chk_req;
    bit          req;
    bit          we;
    logic [31:0] addr;
    logic [31:0] wdata;
    bit          chk_cnt;
    bit          chk_state;
  } exp_t;

  exp_t        exp_c;
  logic [31:0] exp_q[$];

  // Cache model: each line remembers the full address it holds.
  bit          m_valid [16];
  logic [31:0] m_addr  [16];
  logic [31:0] m_data  [16];
  logic [31:0] m_hits, m_misses;

  int          tests = 0;
  int          fails = 0;
  int          stall_run = 0;
  int          last_run = 0;
  logic [31:0] last_load_data = 32'd0;
  logic [31:0] last_wr_addr = 32'd0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
    end
  endtask

  always @(negedge clk) begin
    if (exp_c.en) begin
      chk("mem_stall", {31'd0, mem_stall}, {31'd0, exp_c.stall});
      if (exp_c.pop) begin
        if (exp_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL scoreboard_empty: got load result %h expected none", read_data);
        end else begin
          chk("read_data", read_data, exp_q.pop_front());
          last_load_data = read_data;
        end
      end else if (!exp_c.stall) begin
        chk("read_data_zero", read_data, 32'd0);
      end
      if (exp_c.chk_req) begin
        chk("mem_req", {31'd0, mem_req}, {31'd0, exp_c.req});
        if (exp_c.req) begin
          chk("mem_we", {31'd0, mem_we}, {31'd0, exp_c.we});
          chk("mem_addr", mem_addr, exp_c.addr);
          if (exp_c.we) chk("mem_wdata", mem_wdata, exp_c.wdata);
        end
      end
      if (exp_c.chk_cnt) begin
        chk("hit_count", hit_count, m_hits);
        chk("miss_count", miss_count, m_misses);
      end
      if (exp_c.chk_state) chk("state_idle", {30'd0, state_dbg}, 32'd0);
      if (mem_stall) stall_run++;
      else begin
        if (stall_run > 0) last_run = stall_run;
        stall_run = 0;
      end
      if (mem_req && mem_we) last_wr_addr = mem_addr;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_exp(input bit stall, input bit req, input bit we,
                         input logic [31:0] a, input logic [31:0] wd, input bit pop);
    exp_c.en        = 1'b1;
    exp_c.stall     = stall;
    exp_c.pop       = pop;
    exp_c.chk_req   = 1'b1;
    exp_c.req       = req;
    exp_c.we        = we;
    exp_c.addr      = a;
    exp_c.wdata     = wd;
    exp_c.chk_cnt   = 1'b1;
    exp_c.chk_state = 1'b0;
  endtask

  task automatic clear_model();
    for (int i = 0; i < 16; i++) m_valid[i] = 1'b0;
    m_hits   = 32'd0;
    m_misses = 32'd0;
    exp_q.delete();
  endtask

  // One reset cycle (registered outputs not yet checked), then one idle cycle.
  task automatic rst_cycle();
    rst = 1'b1;
    mem_ack = 1'b0;
    set_exp(1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0);
    exp_c.chk_req = 1'b0;
    exp_c.chk_cnt = 1'b0;
    tick();
    clear_model();
    rst = 1'b0;
    mem_read = 1'b0;
    mem_write = 1'b0;
    set_exp(1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0);
    exp_c.chk_state = 1'b1;
    tick();
  endtask

  // d = cycles between mem_req rising and the ack; rv = backing read data.
  task automatic access(input bit wr, input bit rd, input logic [31:0] a,
                        input logic [31:0] wd, input int d, input logic [31:0] rv);
    int idx;
    bit load;
    bit hit;
    idx  = int'(a[3:0]);
    load = rd && !wr;
    hit  = m_valid[idx] && (m_addr[idx] == a);
    address    = a;
    write_data = wd;
    mem_read   = rd;
    mem_write  = wr;
    if (!wr && !rd) begin
      mem_ack = 1'($urandom_range(0, 1));
      set_exp(1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0);
      tick();
      mem_ack = 1'b0;
      return;
    end
    if (load && hit) begin
      exp_q.push_back(m_data[idx]);
      set_exp(1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 1'b1);
      tick();
      if (m_hits != 32'hFFFF_FFFF) m_hits++;
      mem_read = 1'b0;
      return;
    end
    set_exp(1'b1, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0);
    tick();
    if (load && m_misses != 32'hFFFF_FFFF) m_misses++;
    for (int k = 0; k <= d; k++) begin
      set_exp(1'b1, 1'b1, wr, a, wd, 1'b0);
      mem_ack   = (k == d);
      mem_rdata = (k == d) ? rv : $urandom();
      tick();
    end
    mem_ack = 1'b0;
    if (load) begin
      m_valid[idx] = 1'b1;
      m_addr[idx]  = a;
      m_data[idx]  = rv;
      exp_q.push_back(rv);
    end else if (hit) begin
      m_data[idx] = wd;
    end
    set_exp(1'b0, 1'b0, 1'b0, 32'd0, 32'd0, load);
    tick();
    mem_read  = 1'b0;
    mem_write = 1'b0;
  endtask

  initial begin
    exp_c.en  = 1'b0;
    rst       = 1'b1;
    address   = 32'd0;
    write_data = 32'd0;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    mem_ack   = 1'b0;
    mem_rdata = 32'd0;
    clear_model();
    rst_cycle();

    // Cold load miss with ack three cycles after mem_req.
    access(1'b0, 1'b1, 32'h10, 32'd0, 3, 32'hDEAD_BEEF);
    chk("t1_stall_len", last_run, 32'd5);
    chk("t1_rdata", last_load_data, 32'hDEAD_BEEF);
    chk("t1_miss_count", miss_count, 32'd1);

    access(1'b0, 1'b1, 32'h10, 32'd0, 0, 32'd0);
    chk("t2_hit_count", hit_count, 32'd1);
    chk("t2_rdata", last_load_data, 32'hDEAD_BEEF);

    access(1'b1, 1'b0, 32'h10, 32'h1234_5678, 1, 32'd0);
    chk("t3_wr_addr", last_wr_addr, 32'h10);
    access(1'b0, 1'b1, 32'h10, 32'd0, 0, 32'd0);
    chk("t3_hit_rdata", last_load_data, 32'h1234_5678);
    access(1'b1, 1'b0, 32'h20, 32'h0BAD_F00D, 2, 32'd0);
    access(1'b0, 1'b1, 32'h20, 32'd0, 0, 32'hA5A5_0020);
    chk("t3_miss_count", miss_count, 32'd2);
    chk("t3_uncached_rdata", last_load_data, 32'hA5A5_0020);

    // Conflict on index 0.
    rst_cycle();
    access(1'b0, 1'b1, 32'h10, 32'd0, 1, 32'h1111_0010);
    access(1'b0, 1'b1, 32'h20, 32'd0, 2, 32'h2222_0020);
    access(1'b0, 1'b1, 32'h10, 32'd0, 0, 32'h3333_0010);
    chk("t4_miss_count", miss_count, 32'd3);
    chk("t4_hit_count", hit_count, 32'd0);

    // Read and write together behave as a store; stray ack while idle.
    access(1'b1, 1'b1, 32'h30, 32'h5555_AAAA, 1, 32'd0);
    chk("t5_wr_addr", last_wr_addr, 32'h30);
    chk("t5_miss_count", miss_count, 32'd3);
    chk("t5_hit_count", hit_count, 32'd0);
    mem_ack = 1'b1;
    set_exp(1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0);
    tick();
    mem_ack = 1'b0;
    set_exp(1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0);
    exp_c.chk_state = 1'b1;
    tick();

    // Reset while waiting in RD_MISS.
    rst_cycle();
    address  = 32'h44;
    mem_read = 1'b1;
    set_exp(1'b1, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0);
    tick();
    m_misses++;
    for (int k = 0; k < 2; k++) begin
      set_exp(1'b1, 1'b1, 1'b0, 32'h44, 32'd0, 1'b0);
      tick();
    end
    mem_read = 1'b1;
    rst_cycle();
    chk("t6_miss_count", miss_count, 32'd0);
    chk("t6_mem_req", {31'd0, mem_req}, 32'd0);
    access(1'b0, 1'b1, 32'h44, 32'd0, 1, 32'hC0FF_EE44);
    chk("t6_remiss_count", miss_count, 32'd1);

    // Random traffic over a small address pool so hits and conflicts are common.
    rst_cycle();
    for (int n = 0; n < 400; n++) begin
      int          kind;
      logic [31:0] a;
      kind = int'($urandom_range(0, 9));
      a = ($urandom_range(0, 1) == 1 ? 32'h8000_0000 : 32'd0) | 32'($urandom_range(0, 47));
      case (kind)
        0:             access(1'b0, 1'b0, a, 32'd0, 0, 32'd0);
        1, 2, 3, 4, 5: access(1'b0, 1'b1, a, $urandom(), int'($urandom_range(0, 4)), $urandom());
        6, 7, 8:       access(1'b1, 1'b0, a, $urandom(), int'($urandom_range(0, 4)), $urandom());
        default:       access(1'b1, 1'b1, a, $urandom(), int'($urandom_range(0, 4)), $urandom());
      endcase
    end
    exp_c.en = 1'b0;
    chk("final_hit_count", hit_count, m_hits);
    chk("final_miss_count", miss_count, m_misses);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
